sprite_fetch: RTL and testbench

- Sequencer directly upstream of the sprite engine's data inputs.
- Pulses `sort` at the start of the OAM phase, then walks `index` through the sorted sprite slots.
- For each slot it reads both tile bit-planes from VRAM at the sprite-supplied address and delivers them on `data`/`data1`, qualified by `dvalid`.
- Sits between the video timing controller and the VRAM arbiter, and runs once per visible line.

---
 rtl/sprite_fetch.sv | 155 +++++++++++++++
 tb/tb_sprite_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch.sv
`default_nettype none
// sprite_fetch: per-line sequencer that walks the sorted sprite slots and
// fetches both tile bit-planes of each slot from VRAM for the sprite engine.
module sprite_fetch #(
  parameter int NUM_SLOTS = 10,
  parameter int SETTLE    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oam_start,
  input  logic        fetch_start,
  input  logic        abort,
  output logic        sort,
  output logic [3:0]  index,
  input  logic [10:0] spr_addr,
  output logic        vram_req,
  output logic [11:0] vram_addr,
  input  logic        vram_ack,
  input  logic [7:0]  vram_data,
  input  logic [7:0]  vram_data1,
  output logic [7:0]  data,
  output logic [7:0]  data1,
  output logic [1:0]  dvalid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ0,
    ST_DV0,
    ST_REQ1,
    ST_DV1,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'(NUM_SLOTS - 1);
  localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);
  // With no settle time a new slot issues its first request immediately.
  localparam state_t     SLOT_ENTRY = (SETTLE == 0) ? ST_REQ0 : ST_SETTLE;

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  data1_q, data1_d;
  logic        sort_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= 4'd0;
      cnt_q   <= 3'd0;
      data_q  <= 8'd0;
      data1_q <= 8'd0;
      sort_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      data1_q <= data1_d;
      sort_q  <= oam_start;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    data1_d = data1_q;

    case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          index_d = 4'd0;
          cnt_d   = SETTLE_CNT;
          state_d = SLOT_ENTRY;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_REQ0;
        end
      end
      ST_REQ0: begin
        if (vram_ack) begin
          data_d  = vram_data;
          data1_d = vram_data1;
          state_d = ST_DV0;
        end
      end
      ST_DV0: state_d = ST_REQ1;
      ST_REQ1: begin
        if (vram_ack) begin
          data_d  = vram_data;
          data1_d = vram_data1;
          state_d = ST_DV1;
        end
      end
      ST_DV1: state_d = ST_NEXT;
      ST_NEXT: begin
        if (index_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + 4'd1;
          cnt_d   = SETTLE_CNT;
          state_d = SLOT_ENTRY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything: drop any byte accepted this cycle and keep index.
    if (abort) begin
      state_d = ST_IDLE;
      index_d = index_q;
      data_d  = data_q;
      data1_d = data1_q;
    end
  end

  always_comb begin
    vram_req  = 1'b0;
    vram_addr = 12'h000;
    dvalid    = 2'b00;
    case (state_q)
      ST_REQ0: begin
        vram_req  = 1'b1;
        vram_addr = {spr_addr, 1'b0};
      end
      ST_REQ1: begin
        vram_req  = 1'b1;
        vram_addr = {spr_addr, 1'b1};
      end
      ST_DV0:  dvalid = 2'b01;
      ST_DV1:  dvalid = 2'b10;
      default: ;
    endcase
  end

  assign sort  = sort_q;
  assign index = index_q;
  assign data  = data_q;
  assign data1 = data1_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// tb_sprite_fetch: directed and randomized checks of sprite_fetch against a
// schedule-based reference model of one line fetch.
module tb_sprite_fetch;

  localparam int NS = 10;
  localparam int ST = 1;

  localparam int K_WAIT = 0;
  localparam int K_REQ0 = 1;
  localparam int K_DV0  = 2;
  localparam int K_REQ1 = 3;
  localparam int K_DV1  = 4;
  localparam int K_NEXT = 5;
  localparam int K_DONE = 6;

  typedef struct packed {
    int kind;
    int slot;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        oam_start = 1'b0;
  logic        fetch_start = 1'b0;
  logic        abort = 1'b0;
  logic        sort;
  logic [3:0]  index;
  logic [10:0] spr_addr = 11'h000;
  logic        vram_req;
  logic [11:0] vram_addr;
  logic        vram_ack = 1'b0;
  logic [7:0]  vram_data = 8'h00;
  logic [7:0]  vram_data1 = 8'h00;
  logic [7:0]  data;
  logic [7:0]  data1;
  logic [1:0]  dvalid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  sprite_fetch #(
    .NUM_SLOTS(NS),
    .SETTLE   (ST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .oam_start  (oam_start),
    .fetch_start(fetch_start),
    .abort      (abort),
    .sort       (sort),
    .index      (index),
    .spr_addr   (spr_addr),
    .vram_req   (vram_req),
    .vram_addr  (vram_addr),
    .vram_ack   (vram_ack),
    .vram_data  (vram_data),
    .vram_data1 (vram_data1),
    .data       (data),
    .data1      (data1),
    .dvalid     (dvalid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a line fetch is a list of cycle kinds; request entries
  // are held until acknowledged, every other entry lasts one cycle.
  ent_t       sched[$];
  logic       m_sort = 1'b0;
  logic [3:0] m_index = 4'd0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_data1 = 8'h00;

  function automatic void push(input int k, input int s);
    ent_t e;
    e.kind = k;
    e.slot = s;
    sched.push_back(e);
  endfunction

  function automatic void build_line();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < ST; w++) push(K_WAIT, s);
      push(K_REQ0, s);
      push(K_DV0, s);
      push(K_REQ1, s);
      push(K_DV1, s);
      push(K_NEXT, s);
    end
    push(K_DONE, NS - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sched.delete();
      m_sort  = 1'b0;
      m_index = 4'd0;
      m_data  = 8'h00;
      m_data1 = 8'h00;
    end else begin
      m_sort = oam_start;
      if (abort) begin
        sched.delete();
      end else if (sched.size() == 0) begin
        if (fetch_start) build_line();
      end else if (sched[0].kind == K_REQ0 || sched[0].kind == K_REQ1) begin
        if (vram_ack) begin
          m_data  = vram_data;
          m_data1 = vram_data1;
          void'(sched.pop_front());
        end
      end else begin
        void'(sched.pop_front());
      end
      if (sched.size() != 0) m_index = 4'(sched[0].slot);
    end
  end

  logic        e_req;
  logic [11:0] e_addr;
  logic [1:0]  e_dv;
  logic        e_done;
  logic        e_busy;

  always @(negedge clk) begin
    e_req  = 1'b0;
    e_addr = 12'h000;
    e_dv   = 2'b00;
    e_done = 1'b0;
    e_busy = (sched.size() != 0);
    if (e_busy) begin
      case (sched[0].kind)
        K_REQ0: begin e_req = 1'b1; e_addr = {spr_addr, 1'b0}; end
        K_REQ1: begin e_req = 1'b1; e_addr = {spr_addr, 1'b1}; end
        K_DV0:  e_dv = 2'b01;
        K_DV1:  e_dv = 2'b10;
        K_DONE: e_done = 1'b1;
        default: ;
      endcase
    end
    check("cmp_sort", sort, m_sort);
    check("cmp_index", index, m_index);
    check("cmp_vram_req", vram_req, e_req);
    check("cmp_vram_addr", vram_addr, e_addr);
    check("cmp_data", data, m_data);
    check("cmp_data1", data1, m_data1);
    check("cmp_dvalid", dvalid, e_dv);
    check("cmp_busy", busy, e_busy);
    check("cmp_done", done, e_done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    int done_cyc;
    int n_dv;
    int dv_err;
    int addr_err;
    int req_run;
    int dv10;
    int dv_at;
    int n_done;
    bit restarted;
    logic [11:0] hold_addr;

    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_index", index, 0);
    check("reset_dvalid", dvalid, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // sort is oam_start delayed one cycle
    oam_start = 1'b1;
    tick();
    oam_start = 1'b0;
    check("sort_high", sort, 1);
    tick();
    check("sort_low", sort, 0);

    // nominal line with ack tied high and a start pulse that must be ignored
    spr_addr   = 11'h123;
    vram_ack   = 1'b1;
    vram_data  = 8'hA5;
    vram_data1 = 8'h3C;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("model_sched_len", sched.size(), 61);
    cyc = 1; done_cyc = 0; n_dv = 0; dv_err = 0; addr_err = 0; restarted = 1'b0;
    while (done_cyc == 0 && cyc < 200) begin
      if (vram_req && vram_addr != {11'h123, n_dv[0]}) addr_err++;
      if (dvalid != 2'b00) begin
        if (dvalid != (n_dv[0] ? 2'b10 : 2'b01) || index != 4'(n_dv / 2)) dv_err++;
        if (n_dv == 0) begin
          check("bank0_data", data, 8'hA5);
          check("bank1_data", data1, 8'h3C);
          check("first_req_addr_plane", {11'h123, 1'b0}, 12'h246);
        end
        n_dv++;
      end
      if (index == 4'd2 && !restarted) begin
        fetch_start = 1'b1;
        restarted   = 1'b1;
      end else begin
        fetch_start = 1'b0;
      end
      if (done) done_cyc = cyc;
      tick();
      cyc++;
    end
    fetch_start = 1'b0;
    check("nom_done_cycle", done_cyc, 61);
    check("nom_dvalid_count", n_dv, 20);
    check("nom_dvalid_seq", dv_err, 0);
    check("nom_addr", addr_err, 0);
    check("nom_last_index", index, 9);
    check("nom_idle_after", busy, 0);

    // stall in REQ1 of slot 0
    vram_ack   = 1'b0;
    vram_data  = 8'h11;
    vram_data1 = 8'h22;
    spr_addr   = 11'h055;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    cyc = 0;
    while (!vram_req && cyc < 20) begin tick(); cyc++; end
    check("stall_req0_seen", vram_req, 1);
    vram_ack = 1'b1;
    tick();
    vram_ack = 1'b0;
    cyc = 0;
    while (!vram_req && cyc < 20) begin tick(); cyc++; end
    hold_addr = vram_addr;
    check("stall_req1_addr", hold_addr, 12'h0AB);
    req_run = 0; dv10 = 0; dv_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (vram_req && vram_addr == hold_addr) req_run++;
      if (dvalid == 2'b10) begin dv10++; dv_at = i; end
      vram_ack = (i == 4);
      tick();
    end
    check("stall_req_cycles", req_run, 5);
    check("stall_dv10_count", dv10, 1);
    check("stall_dv10_when", dv_at, 5);

    // abort coinciding with the REQ0 ack at index 4
    vram_ack = 1'b1;
    cyc = 0;
    while (!(vram_req && index == 4'd4 && !vram_addr[0]) && cyc < 100) begin tick(); cyc++; end
    check("abort_at_index", index, 4);
    check("abort_in_req0", vram_req, 1);
    vram_data  = 8'h77;
    vram_data1 = 8'h88;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_req_low", vram_req, 0);
    check("abort_idle", busy, 0);
    check("abort_no_dvalid", dvalid, 0);
    check("abort_data_kept", data, 8'h11);
    check("abort_data1_kept", data1, 8'h22);
    n_done = 0; n_dv = 0;
    for (int i = 0; i < 70; i++) begin
      if (done) n_done++;
      if (dvalid != 2'b00) n_dv++;
      tick();
    end
    check("abort_no_done", n_done, 0);
    check("abort_no_dvalid_after", n_dv, 0);

    // asynchronous reset while waiting in REQ1
    vram_ack = 1'b1;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    cyc = 0;
    while (!(vram_req && vram_addr[0]) && cyc < 20) begin tick(); cyc++; end
    vram_ack = 1'b0;
    check("rst_in_req1", vram_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_vram_req", vram_req, 0);
    check("rst_vram_addr", vram_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_index", index, 0);
    check("rst_data", data, 0);
    check("rst_data1", data1, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_done", done, 0);
    check("rst_sort", sort, 0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_release_busy", busy, 0);
    check("rst_release_req", vram_req, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      fetch_start = ($urandom_range(0, 19) == 0);
      oam_start   = ($urandom_range(0, 15) == 0);
      abort       = ($urandom_range(0, 149) == 0);
      vram_ack    = ($urandom_range(0, 2) != 0);
      vram_data   = 8'($urandom);
      vram_data1  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) spr_addr = 11'($urandom);
      tick();
    end

    fetch_start = 1'b0;
    oam_start   = 1'b0;
    abort       = 1'b0;
    vram_ack    = 1'b0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
